// File: rtl/cmp_pkg.sv
// Shared types and constants for the serial magnitude comparator.
// The result encoding is a one-hot vector ordered {gt, lt, eq}.
package cmp_pkg;

    typedef enum logic {
        IDLE,
        CMP
    } state_e;

    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_EQ   = 3'b001;
    localparam logic [2:0] RES_LT   = 3'b010;
    localparam logic [2:0] RES_GT   = 3'b100;

endpackage

// File: rtl/slice_cmp.sv
// Combinational comparison of one DIGIT-bit slice.
// With msb_signed set, inverting both top bits maps two's-complement order onto unsigned order.
module slice_cmp #(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             msb_signed,
    output logic             s_eq,
    output logic             s_lt,
    output logic             s_gt
);

    logic [DIGIT-1:0] w_x;
    logic [DIGIT-1:0] w_y;

    always_comb begin
        w_x = x;
        w_y = y;
        if (msb_signed) begin
            w_x[DIGIT-1] = ~x[DIGIT-1];
            w_y[DIGIT-1] = ~y[DIGIT-1];
        end
    end

    assign s_eq = (w_x == w_y);
    assign s_lt = (w_x <  w_y);
    assign s_gt = (w_x >  w_y);

endmodule

// File: rtl/serial_mag_comparator.sv
// Multi-cycle magnitude comparator: DIGIT bits per cycle, MSB slice first, early exit on the
// first differing slice. Result is held in a one-hot {gt, lt, eq} register until overwritten.
module serial_mag_comparator
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             lt,
    output logic             gt
);

    localparam int unsigned NSLICE = WIDTH / DIGIT;
    localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NSLICE - 1);

    state_e           r_state, w_state_next;
    logic [IDXW-1:0]  r_idx, w_idx_next;
    logic [WIDTH-1:0] r_a, w_a_next;
    logic [WIDTH-1:0] r_b, w_b_next;
    logic             r_signed, w_signed_next;
    logic             r_done, w_done_next;
    logic [2:0]       r_res, w_res_next;

    logic [DIGIT-1:0] w_slice_a;
    logic [DIGIT-1:0] w_slice_b;
    logic             w_msb_signed;
    logic             w_s_eq, w_s_lt, w_s_gt;

    assign w_slice_a    = r_a[r_idx*DIGIT +: DIGIT];
    assign w_slice_b    = r_b[r_idx*DIGIT +: DIGIT];
    assign w_msb_signed = r_signed && (r_idx == IDX_TOP);

    slice_cmp #(
        .DIGIT (DIGIT)
    ) u_slice_cmp (
        .x          (w_slice_a),
        .y          (w_slice_b),
        .msb_signed (w_msb_signed),
        .s_eq       (w_s_eq),
        .s_lt       (w_s_lt),
        .s_gt       (w_s_gt)
    );

    always_comb begin
        w_state_next  = r_state;
        w_idx_next    = r_idx;
        w_a_next      = r_a;
        w_b_next      = r_b;
        w_signed_next = r_signed;
        w_done_next   = 1'b0;
        w_res_next    = r_res;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_a_next      = a;
                    w_b_next      = b;
                    w_signed_next = signed_mode;
                    w_idx_next    = IDX_TOP;
                    w_state_next  = CMP;
                end
            end
            CMP: begin
                if (!w_s_eq) begin
                    w_res_next   = w_s_gt ? RES_GT : RES_LT;
                    w_done_next  = 1'b1;
                    w_state_next = IDLE;
                end else if (r_idx == '0) begin
                    w_res_next   = RES_EQ;
                    w_done_next  = 1'b1;
                    w_state_next = IDLE;
                end else begin
                    w_idx_next = r_idx - 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_done   <= 1'b0;
            r_res    <= RES_NONE;
        end else begin
            r_state  <= w_state_next;
            r_idx    <= w_idx_next;
            r_a      <= w_a_next;
            r_b      <= w_b_next;
            r_signed <= w_signed_next;
            r_done   <= w_done_next;
            r_res    <= w_res_next;
        end
    end

    assign busy = (r_state == CMP);
    assign done = r_done;
    assign eq   = r_res[0];
    assign lt   = r_res[1];
    assign gt   = r_res[2];

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Self-checking bench: directed vector table, hand-written corner sequences and a random
// sweep against an arithmetic reference model.
module tb_serial_mag_comparator;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned DIGIT  = 4;
    localparam int unsigned NSLICE = WIDTH / DIGIT;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a, b;
    logic             signed_mode;
    logic             busy, done, eq, lt, gt;

    int checks = 0;
    int errors = 0;
    logic [2:0] prev_res;

    serial_mag_comparator #(
        .WIDTH (WIDTH),
        .DIGIT (DIGIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .busy        (busy),
        .done        (done),
        .eq          (eq),
        .lt          (lt),
        .gt          (gt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             s;
        logic [2:0]       res;  // {gt, lt, eq}
        int               lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] model_res(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic s);
        if (x == y) return 3'b001;
        if (s) return ($signed(x) < $signed(y)) ? 3'b010 : 3'b100;
        return (x < y) ? 3'b010 : 3'b100;
    endfunction

    function automatic int model_lat(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        int unsigned mask;
        mask = (1 << DIGIT) - 1;
        for (int k = 0; k < int'(NSLICE); k++) begin
            int sh;
            sh = (int'(NSLICE) - 1 - k) * int'(DIGIT);
            if (((int'(x) >> sh) & mask) != ((int'(y) >> sh) & mask)) return k + 1;
        end
        return int'(NSLICE);
    endfunction

    // Issues one comparison from idle; while busy, randomly pokes start and the operands,
    // which the DUT must ignore. Returns at the negedge of the done cycle.
    task automatic run_cmp(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                           input logic ts, input logic [2:0] exp_res, input int exp_lat,
                           input string name);
        int lat;
        @(negedge clk);
        start = 1'b1; a = ta; b = tb_; signed_mode = ts;
        @(posedge clk);
        @(negedge clk);
        check({name, " busy after accept"}, {31'd0, busy}, 32'd1);
        check({name, " result held"}, {29'd0, gt, lt, eq}, {29'd0, prev_res});
        lat = 0;
        while (1) begin
            start = 1'($urandom_range(0, 1));
            a = WIDTH'($urandom); b = WIDTH'($urandom); signed_mode = 1'($urandom_range(0, 1));
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done) break;
            if (lat > int'(NSLICE)) begin
                check({name, " done timeout"}, 32'd0, 32'd1);
                break;
            end
        end
        start = 1'b0;
        if (done) begin
            check({name, " latency"}, lat, exp_lat);
            check({name, " result"}, {29'd0, gt, lt, eq}, {29'd0, exp_res});
            check({name, " busy low at done"}, {31'd0, busy}, 32'd0);
            prev_res = exp_res;
        end
        @(negedge clk);
        check({name, " done single pulse"}, {31'd0, done}, 32'd0);
    endtask

    vec_t vecs[$];

    initial begin
        int lat;
        vecs.push_back('{16'hBEEF, 16'hBEEF, 1'b0, 3'b001, 4});
        vecs.push_back('{16'h8000, 16'h7FFF, 1'b0, 3'b100, 1});
        vecs.push_back('{16'h8000, 16'h7FFF, 1'b1, 3'b010, 1});
        vecs.push_back('{16'h1230, 16'h1231, 1'b0, 3'b010, 4});
        vecs.push_back('{16'hFFFE, 16'hFFFF, 1'b1, 3'b010, 4});
        vecs.push_back('{16'h0001, 16'h0000, 1'b0, 3'b100, 4});
        vecs.push_back('{16'h0000, 16'h0000, 1'b1, 3'b001, 4});
        vecs.push_back('{16'h7FFF, 16'h8000, 1'b1, 3'b100, 1});
        vecs.push_back('{16'h0F00, 16'h0E00, 1'b1, 3'b100, 2});
        vecs.push_back('{16'hA5C3, 16'hA5D3, 1'b0, 3'b010, 3});

        rst = 1'b1; start = 1'b0; a = '0; b = '0; signed_mode = 1'b0;
        prev_res = 3'b000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset outputs", {27'd0, busy, done, gt, lt, eq}, 32'd0);
        rst = 1'b0;

        // Reset one cycle into a comparison: immediate abort, no done afterwards.
        @(negedge clk);
        start = 1'b1; a = 16'h1234; b = 16'h1234;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort outputs", {27'd0, busy, done, gt, lt, eq}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        lat = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || busy) lat++;
        end
        check("no done after abort", lat, 0);
        run_cmp(16'h1234, 16'h1234, 1'b0, 3'b001, 4, "post-reset");

        foreach (vecs[i]) run_cmp(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].res, vecs[i].lat,
                                  $sformatf("vec%0d", i));

        // Back-to-back with start held high; operands scrambled during the first compare.
        @(negedge clk);
        start = 1'b1; a = 16'h0001; b = 16'h0000; signed_mode = 1'b0;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            a = WIDTH'($urandom); b = WIDTH'($urandom);
            if (!done) begin
                @(posedge clk);
                lat++;
            end
        end while (!done && lat <= int'(NSLICE));
        check("b2b pair1 latency", lat, 4);
        check("b2b pair1 result", {29'd0, gt, lt, eq}, 32'b100);
        a = 16'h2000; b = 16'h1000;
        @(posedge clk);
        @(negedge clk);
        check("b2b pair2 accepted", {30'd0, busy, done}, 32'b10);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("b2b pair2 done", {31'd0, done}, 32'd1);
        check("b2b pair2 result", {29'd0, gt, lt, eq}, 32'b100);
        prev_res = 3'b100;

        // Random sweep; b mostly shares a's upper slices so latencies are spread.
        for (int n = 0; n < 10000; n++) begin
            logic [WIDTH-1:0] ra, rb;
            logic             rs;
            int               keep;
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            keep = $urandom_range(0, int'(NSLICE));
            if (keep > 0) begin
                logic [WIDTH-1:0] hi_mask;
                hi_mask = ~(WIDTH'({WIDTH{1'b1}}) >> (keep * int'(DIGIT)));
                rb = (ra & hi_mask) | (rb & ~hi_mask);
            end
            rs = 1'($urandom_range(0, 1));
            run_cmp(ra, rb, rs, model_res(ra, rb, rs), model_lat(ra, rb), $sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
